mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle sequencer for the MIPS datapath. It replaces single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and mux selects in each step. It talks to the shared instruction/data memory through a req/ack handshake, with a stall watchdog. It also tracks retired instructions and latches sticky error status.

## Interface
- `STALL_LIMIT`, 255: max consecutive un-acked `mem_req` cycles before trap (1..255).
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `run` input 1: fetch of a new instruction starts only while high.
- `op` input 6: instruction [31:26], taken from the IR.
- `func` input 6: instruction [5:0], taken from the IR.
- `zero` input 1: ALU zero flag.
- `mem_ack` input 1: memory completes the current access this cycle.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: write qualifier for `mem_req`.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_we` output 1: instruction register load.
- `pc_we` output 1: PC load, covering both unconditional and branch-qualified loads.
- `reg_we` output 1: register-file write.
- `regdst` output 1: destination select; 1 = rd, 0 = rt.
- `memtoreg` output 1: writeback source; 1 = MDR, 0 = ALUOut.
- `alusrc_a` output 1: ALU A source; 0 = PC, 1 = rs.
- `alusrc_b` output 2: ALU B source; 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `pc_src` output 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluctrl` output 3: ALU operation; 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `busy` output 1: high in every state except IDLE and TRAP.
- `err` output 1: sticky, set on entry to TRAP.
- `err_code` output 2: 01 = illegal op/func, 10 = memory stall timeout.
- `instr_retired` output 32: count of completed instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, TRAP.
- All outputs are Moore outputs of the state. Exceptions: `pc_we` in BRANCH is `zero`; `pc_we`/`ir_we` in FETCH are `mem_ack`.
- Unlisted outputs are 0 in every state.
- IDLE: if `run` → FETCH.
- FETCH: `mem_req=1`, `iord=0`, `alusrc_a=0`, `alusrc_b=01`, `aluctrl=010`, `pc_src=00`. On `mem_ack` → DECODE.
- DECODE: `alusrc_a=0`, `alusrc_b=11`, `aluctrl=010` (branch target into ALUOut). Dispatch on `op`/`func`:
  - op 000000 with func 100000/100010/100100/100101/101010 → EXEC_R.
  - op 100011 (lw) or 101011 (sw) → MEMADR.
  - op 001000 (addi) → EXEC_I.
  - op 000100 (beq) → BRANCH.
  - op 000010 (j) → JUMP.
  - Anything else → TRAP with `err_code=01`.
- MEMADR: `alusrc_a=1`, `alusrc_b=10`, add. lw → MEMRD; sw → MEMWR.
- MEMRD: `mem_req=1`, `iord=1`. On ack → MEMWB.
- MEMWR: `mem_req=1`, `mem_we=1`, `iord=1`. On ack → retire.
- MEMWB: `reg_we=1`, `regdst=0`, `memtoreg=1`. Retire.
- EXEC_R: `alusrc_a=1`, `alusrc_b=00`, `aluctrl` from func. → ALUWB with `regdst=1`.
- EXEC_I: `alusrc_a=1`, `alusrc_b=10`, add. → ALUWB with `regdst=0`.
- ALUWB: `reg_we=1`, `memtoreg=0`. Retire.
- BRANCH: `alusrc_a=1`, `alusrc_b=00`, sub, `pc_src=01`, `pc_we=zero`. Retire.
- JUMP: `pc_src=10`, `pc_we=1`. Retire.
- Retire: `instr_retired` increments on the final cycle of the instruction. Next state is FETCH if `run`, else IDLE.
  - Deasserting `run` mid-instruction never aborts it.
- Watchdog: an 8-bit stall counter clears on any cycle without `mem_req`, or with `mem_req` and `mem_ack`; otherwise it increments.
  - When the counter equals `STALL_LIMIT` with no ack → TRAP, `err_code=10`.
  - An ack in that same cycle wins.
- TRAP: all enables 0, `busy=0`. Exited only by reset.

## Timing
- Reset (async assert, sync deassert assumed upstream): state IDLE, counters 0, `err=0`, `err_code=00`. All outputs 0 except `aluctrl=000`.
- Latencies with zero-wait memory (ack in the request cycle), FETCH to retire inclusive:
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j: 3 cycles.
- Each cycle without ack adds exactly one cycle.
- `mem_req` is held stable, with stable `iord`/`mem_we`, until the ack cycle. It deasserts the cycle after.
- Reset mid-access drops `mem_req` immediately (asynchronously).

## Structure
- Shared package `mips_pkg`: state enum, opcode/func constants, `aluctrl` codes, `alusrc_b`/`pc_src` encodings, `err_code` values.
- Sub-module `alu_decoder` (combinational func→`aluctrl`), reused by other datapath blocks.

## Test plan
- Reset, `run=1`, add (op 0, func 100000), ack every request → FETCH, DECODE, EXEC_R, ALUWB; `reg_we=1`, `regdst=1` in cycle 4; `instr_retired=1`.
- lw with `mem_ack` delayed 3 cycles on MEMRD → 8 cycles total; `iord=1` held throughout; `memtoreg=1` at MEMWB.
- beq with `zero=1` then `zero=0` → `pc_we` 1 then 0 in BRANCH; both retire at cycle 3.
- op 111111 → TRAP after DECODE; `err=1`, `err_code=01`; `busy=0`; stays put with `run=1` until `reset_n` low.
- `STALL_LIMIT=4`, never ack in FETCH → TRAP after 5 FETCH cycles with `err_code=10`. Repeat with ack on cycle 5 → no trap.
- Drop `run` during EXEC_R → instruction retires, enters IDLE, `mem_req` stays 0. Assert `reset_n=0` mid-MEMWR → outputs clear the same cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states,
// instruction field codes, ALU operation codes, mux encodings and error codes.
package mips_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_MEMADR,
      ST_MEMRD,
      ST_MEMWR,
      ST_MEMWB,
      ST_EXEC_R,
      ST_EXEC_I,
      ST_ALUWB,
      ST_BRANCH,
      ST_JUMP,
      ST_TRAP
   } state_t;

   // Opcodes (instruction [31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes (instruction [5:0])
   localparam logic [5:0] FUNC_ADD = 6'b100000;
   localparam logic [5:0] FUNC_SUB = 6'b100010;
   localparam logic [5:0] FUNC_AND = 6'b100100;
   localparam logic [5:0] FUNC_OR  = 6'b100101;
   localparam logic [5:0] FUNC_SLT = 6'b101010;

   // ALU operations
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] ALUB_RT      = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Sticky error codes
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_STALL   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake. The controller is the master:
// it raises mem_req with a stable address select and write qualifier and
// holds them until the memory answers with mem_ack.
interface mips_multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ack;

   modport master (output mem_req, output mem_we, output iord, input mem_ack);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/alu_decoder.sv
// Combinational R-type function decoder: maps func to an ALU operation and
// flags function codes the datapath does not implement.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] func,
   output logic [2:0] aluctrl,
   output logic       legal
);

   // Map func to ALU op; unknown codes fall back to add and are flagged illegal
   always_comb begin
      aluctrl = ALU_ADD;
      legal   = 1'b1;
      case (func)
         FUNC_ADD: aluctrl = ALU_ADD;
         FUNC_SUB: aluctrl = ALU_SUB;
         FUNC_AND: aluctrl = ALU_AND;
         FUNC_OR:  aluctrl = ALU_OR;
         FUNC_SLT: aluctrl = ALU_SLT;
         default:  legal   = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, drives datapath enables and mux selects as
// Moore outputs, watches the memory handshake for stalls, counts retired
// instructions and latches a sticky error code on entry to TRAP.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned STALL_LIMIT = 255
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   run,
   input  logic [5:0]             op,
   input  logic [5:0]             func,
   input  logic                   zero,
   mips_multicycle_ctrl_if.master mem,
   output logic                   ir_we,
   output logic                   pc_we,
   output logic                   reg_we,
   output logic                   regdst,
   output logic                   memtoreg,
   output logic                   alusrc_a,
   output logic [1:0]             alusrc_b,
   output logic [1:0]             pc_src,
   output logic [2:0]             aluctrl,
   output logic                   busy,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [31:0]            instr_retired
);

   localparam logic [7:0] STALL_LIMIT_C = 8'(STALL_LIMIT);

   state_t      state_reg, state_next;
   logic [7:0]  stall_cnt_reg, stall_cnt_next;
   logic [31:0] instr_retired_reg;
   logic        err_reg;
   logic [1:0]  err_code_reg;
   logic        wb_rd_reg, wb_rd_next;   // ALUWB destination: 1 = rd (R-type), 0 = rt (addi)
   logic        retire;
   logic [1:0]  trap_code;
   logic        mem_req_int, mem_we_int, iord_int;
   logic [2:0]  rfunc_aluctrl;
   logic        rfunc_legal;

   alu_decoder u_alu_decoder (
      .func    (func),
      .aluctrl (rfunc_aluctrl),
      .legal   (rfunc_legal)
   );

   // State, watchdog, retire counter and sticky error registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg         <= ST_IDLE;
         stall_cnt_reg     <= 8'd0;
         instr_retired_reg <= 32'd0;
         err_reg           <= 1'b0;
         err_code_reg      <= ERR_NONE;
         wb_rd_reg         <= 1'b0;
      end else begin
         state_reg     <= state_next;
         stall_cnt_reg <= stall_cnt_next;
         wb_rd_reg     <= wb_rd_next;
         if (retire) begin
            instr_retired_reg <= instr_retired_reg + 32'd1;
         end
         if (trap_code != ERR_NONE) begin
            err_reg      <= 1'b1;
            err_code_reg <= trap_code;
         end
      end
   end

   // Next-state decode and per-state datapath controls
   always_comb begin
      state_next  = state_reg;
      wb_rd_next  = wb_rd_reg;
      retire      = 1'b0;
      trap_code   = ERR_NONE;
      mem_req_int = 1'b0;
      mem_we_int  = 1'b0;
      iord_int    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      reg_we      = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      alusrc_a    = 1'b0;
      alusrc_b    = ALUB_RT;
      pc_src      = PCSRC_ALU;
      aluctrl     = ALU_AND;
      busy        = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (run) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req_int = 1'b1;
            alusrc_b    = ALUB_FOUR;
            aluctrl     = ALU_ADD;
            ir_we       = mem.mem_ack;
            pc_we       = mem.mem_ack;
            if (mem.mem_ack) state_next = ST_DECODE;
         end
         ST_DECODE: begin
            // Precompute the branch target into ALUOut while dispatching
            alusrc_b = ALUB_IMM_SH2;
            aluctrl  = ALU_ADD;
            case (op)
               OP_RTYPE: begin
                  if (rfunc_legal) state_next = ST_EXEC_R;
                  else             trap_code  = ERR_ILLEGAL;
               end
               OP_LW, OP_SW: state_next = ST_MEMADR;
               OP_ADDI:      state_next = ST_EXEC_I;
               OP_BEQ:       state_next = ST_BRANCH;
               OP_J:         state_next = ST_JUMP;
               default:      trap_code  = ERR_ILLEGAL;
            endcase
         end
         ST_MEMADR: begin
            alusrc_a   = 1'b1;
            alusrc_b   = ALUB_IMM;
            aluctrl    = ALU_ADD;
            state_next = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            mem_req_int = 1'b1;
            iord_int    = 1'b1;
            if (mem.mem_ack) state_next = ST_MEMWB;
         end
         ST_MEMWR: begin
            mem_req_int = 1'b1;
            mem_we_int  = 1'b1;
            iord_int    = 1'b1;
            if (mem.mem_ack) begin
               retire     = 1'b1;
               state_next = run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_MEMWB: begin
            reg_we     = 1'b1;
            memtoreg   = 1'b1;
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_EXEC_R: begin
            alusrc_a   = 1'b1;
            alusrc_b   = ALUB_RT;
            aluctrl    = rfunc_aluctrl;
            wb_rd_next = 1'b1;
            state_next = ST_ALUWB;
         end
         ST_EXEC_I: begin
            alusrc_a   = 1'b1;
            alusrc_b   = ALUB_IMM;
            aluctrl    = ALU_ADD;
            wb_rd_next = 1'b0;
            state_next = ST_ALUWB;
         end
         ST_ALUWB: begin
            reg_we     = 1'b1;
            regdst     = wb_rd_reg;
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_BRANCH: begin
            alusrc_a   = 1'b1;
            alusrc_b   = ALUB_RT;
            aluctrl    = ALU_SUB;
            pc_src     = PCSRC_ALUOUT;
            pc_we      = zero;
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = run ? ST_FETCH : ST_IDLE;
         end
         ST_TRAP: begin
            busy = 1'b0;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase

      // Watchdog: a request left unanswered at the limit traps; an ack wins
      if (mem_req_int && !mem.mem_ack && stall_cnt_reg == STALL_LIMIT_C) begin
         trap_code = ERR_STALL;
      end
      if (trap_code != ERR_NONE) begin
         state_next = ST_TRAP;
      end

      stall_cnt_next = (mem_req_int && !mem.mem_ack) ? stall_cnt_reg + 8'd1 : 8'd0;
   end

   assign mem.mem_req    = mem_req_int;
   assign mem.mem_we     = mem_we_int;
   assign mem.iord       = iord_int;
   assign err            = err_reg;
   assign err_code       = err_code_reg;
   assign instr_retired  = instr_retired_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl (STALL_LIMIT = 4). Each task walks
// one instruction scenario cycle by cycle and compares the full control
// vector against hand-derived per-state values.
module tb_mips_multicycle_ctrl;

   logic        clk;
   logic        reset_n;
   logic        run;
   logic [5:0]  op;
   logic [5:0]  func;
   logic        zero;
   logic        ir_we, pc_we, reg_we, regdst, memtoreg, alusrc_a, busy, err;
   logic [1:0]  alusrc_b, pc_src, err_code;
   logic [2:0]  aluctrl;
   logic [31:0] instr_retired;

   int errors = 0;
   int checks = 0;

   mips_multicycle_ctrl_if mif ();

   mips_multicycle_ctrl #(.STALL_LIMIT(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .run           (run),
      .op            (op),
      .func          (func),
      .zero          (zero),
      .mem           (mif),
      .ir_we         (ir_we),
      .pc_we         (pc_we),
      .reg_we        (reg_we),
      .regdst        (regdst),
      .memtoreg      (memtoreg),
      .alusrc_a      (alusrc_a),
      .alusrc_b      (alusrc_b),
      .pc_src        (pc_src),
      .aluctrl       (aluctrl),
      .busy          (busy),
      .err           (err),
      .err_code      (err_code),
      .instr_retired (instr_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {mem_req, mem_we, iord, ir_we, pc_we, reg_we, regdst, memtoreg, alusrc_a, alusrc_b, pc_src, aluctrl, busy}
   logic [16:0] obs;
   assign obs = {mif.mem_req, mif.mem_we, mif.iord, ir_we, pc_we, reg_we, regdst, memtoreg,
                 alusrc_a, alusrc_b, pc_src, aluctrl, busy};

   function automatic logic [16:0] exp_vec(input logic req, input logic we, input logic ad,
                                           input logic irw, input logic pcw, input logic rw,
                                           input logic rd, input logic m2r, input logic asa,
                                           input logic [1:0] asb, input logic [1:0] psrc,
                                           input logic [2:0] alu, input logic bsy);
      return {req, we, ad, irw, pcw, rw, rd, m2r, asa, asb, psrc, alu, bsy};
   endfunction

   logic [16:0] V_IDLE, V_TRAP, V_FETCH_ACK, V_FETCH_NOACK, V_DECODE, V_EXEC_ADD, V_EXEC_SUB;
   logic [16:0] V_EXEC_I, V_MEMADR, V_ALUWB_R, V_ALUWB_I, V_MEMRD, V_MEMWR, V_MEMWB;
   logic [16:0] V_BRANCH_T, V_BRANCH_N, V_JUMP;

   // One cycle: drive inputs just after the falling edge, sample 1 time unit later
   task automatic tick(input logic r, input logic a, input logic z);
      @(negedge clk);
      run         = r;
      mif.mem_ack = a;
      zero        = z;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n     = 1'b0;
      run         = 1'b0;
      mif.mem_ack = 1'b0;
      zero        = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      checks++;
      if (obs !== V_IDLE) begin
         errors++; $display("FAIL reset_outputs got=%h want=%h", obs, V_IDLE);
      end
      checks++;
      if (err !== 1'b0 || err_code !== 2'b00) begin
         errors++; $display("FAIL reset_err got=%b/%b want=0/00", err, err_code);
      end
      checks++;
      if (instr_retired !== 32'd0) begin
         errors++; $display("FAIL reset_retired got=%0d want=0", instr_retired);
      end
      @(negedge clk);
      reset_n = 1'b1;
      $display("reset: outputs=%h err=%b retired=%0d", obs, err, instr_retired);
   endtask

   task automatic test_add();
      logic [16:0] ev [5];
      ev = '{V_IDLE, V_FETCH_ACK, V_DECODE, V_EXEC_ADD, V_ALUWB_R};
      op = 6'b000000; func = 6'b100000;
      for (int i = 0; i < 5; i++) begin
         tick(i == 0, i == 1, 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL add_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== V_IDLE || instr_retired !== 32'd1) begin
         errors++; $display("FAIL add_retire got=%h/%0d want=%h/1", obs, instr_retired, V_IDLE);
      end
      $display("add: retired=%0d", instr_retired);
   endtask

   task automatic test_lw_wait();
      logic [16:0] ev [9];
      logic        av [9];
      ev = '{V_IDLE, V_FETCH_ACK, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
      av = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      op = 6'b100011;
      for (int i = 0; i < 9; i++) begin
         tick(i == 0, av[i], 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL lw_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== V_IDLE || instr_retired !== 32'd2) begin
         errors++; $display("FAIL lw_retire got=%h/%0d want=%h/2", obs, instr_retired, V_IDLE);
      end
      $display("lw (3 wait cycles): retired=%0d", instr_retired);
   endtask

   task automatic test_beq();
      logic z;
      op = 6'b000100;
      for (int k = 0; k < 2; k++) begin
         z = (k == 0);
         tick(1'b1, 1'b0, 1'b0);
         tick(1'b0, 1'b1, 1'b0);
         checks++;
         if (obs !== V_FETCH_ACK) begin
            errors++; $display("FAIL beq%0d_fetch got=%h want=%h", k, obs, V_FETCH_ACK);
         end
         tick(1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== V_DECODE) begin
            errors++; $display("FAIL beq%0d_decode got=%h want=%h", k, obs, V_DECODE);
         end
         tick(1'b0, 1'b0, z);
         checks++;
         if (obs !== (z ? V_BRANCH_T : V_BRANCH_N)) begin
            errors++; $display("FAIL beq%0d_branch got=%h want=%h", k, obs, z ? V_BRANCH_T : V_BRANCH_N);
         end
         tick(1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== V_IDLE || instr_retired !== 32'(3 + k)) begin
            errors++; $display("FAIL beq%0d_retire got=%h/%0d want=%h/%0d", k, obs, instr_retired, V_IDLE, 3 + k);
         end
         $display("beq zero=%b: retired=%0d", z, instr_retired);
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] ev [9];
      logic        rv [9];
      logic        av [9];
      ev = '{V_IDLE, V_FETCH_ACK, V_DECODE, V_EXEC_I, V_ALUWB_I, V_FETCH_ACK, V_DECODE, V_JUMP, V_IDLE};
      rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      av = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      op = 6'b001000;
      for (int i = 0; i < 9; i++) begin
         if (i == 5) op = 6'b000010;
         tick(rv[i], av[i], 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL b2b_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      checks++;
      if (instr_retired !== 32'd6) begin
         errors++; $display("FAIL b2b_retired got=%0d want=6", instr_retired);
      end
      $display("addi+j back to back: retired=%0d", instr_retired);
   endtask

   task automatic test_sw_wait();
      logic [16:0] ev [7];
      logic        av [7];
      ev = '{V_IDLE, V_FETCH_ACK, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR, V_IDLE};
      av = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      op = 6'b101011;
      for (int i = 0; i < 7; i++) begin
         tick(i == 0, av[i], 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL sw_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      checks++;
      if (instr_retired !== 32'd7) begin
         errors++; $display("FAIL sw_retired got=%0d want=7", instr_retired);
      end
      $display("sw (1 wait cycle): retired=%0d", instr_retired);
   endtask

   task automatic test_run_drop();
      logic [16:0] ev [7];
      logic        rv [7];
      ev = '{V_IDLE, V_FETCH_ACK, V_DECODE, V_EXEC_SUB, V_ALUWB_R, V_IDLE, V_IDLE};
      rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      op = 6'b000000; func = 6'b100010;
      for (int i = 0; i < 7; i++) begin
         tick(rv[i], i == 1, 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL rundrop_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      checks++;
      if (instr_retired !== 32'd8) begin
         errors++; $display("FAIL rundrop_retired got=%0d want=8", instr_retired);
      end
      $display("sub with run dropped in EXEC_R: retired=%0d", instr_retired);
   endtask

   task automatic test_stall_ack5();
      logic [16:0] ev [9];
      logic        av [9];
      ev = '{V_IDLE, V_FETCH_NOACK, V_FETCH_NOACK, V_FETCH_NOACK, V_FETCH_NOACK,
             V_FETCH_ACK, V_DECODE, V_JUMP, V_IDLE};
      av = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      op = 6'b000010;
      for (int i = 0; i < 9; i++) begin
         tick(i == 0, av[i], 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL stallack_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      checks++;
      if (err !== 1'b0 || instr_retired !== 32'd9) begin
         errors++; $display("FAIL stallack_state got=err%b/%0d want=err0/9", err, instr_retired);
      end
      $display("fetch acked on 5th cycle: err=%b retired=%0d", err, instr_retired);
   endtask

   task automatic test_reset_mid_memwr();
      logic [16:0] ev [5];
      ev = '{V_IDLE, V_FETCH_ACK, V_DECODE, V_MEMADR, V_MEMWR};
      op = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         tick(i == 0, i == 1, 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL rstwr_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== V_IDLE || instr_retired !== 32'd0) begin
         errors++; $display("FAIL rstwr_async got=%h/%0d want=%h/0", obs, instr_retired, V_IDLE);
      end
      @(negedge clk);
      reset_n = 1'b1;
      $display("reset during MEMWR: outputs=%h retired=%0d", obs, instr_retired);
   endtask

   task automatic test_illegal();
      logic [16:0] ev [6];
      logic        rv [6];
      ev = '{V_IDLE, V_FETCH_ACK, V_DECODE, V_TRAP, V_TRAP, V_TRAP};
      rv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      op = 6'b111111;
      for (int i = 0; i < 6; i++) begin
         tick(rv[i], i == 1, 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL illegal_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      checks++;
      if (err !== 1'b1 || err_code !== 2'b01) begin
         errors++; $display("FAIL illegal_err got=%b/%b want=1/01", err, err_code);
      end
      $display("illegal op: err=%b err_code=%b busy=%b", err, err_code, busy);
      apply_reset();
      #1;
      checks++;
      if (err !== 1'b0 || err_code !== 2'b00 || obs !== V_IDLE) begin
         errors++; $display("FAIL illegal_clear got=%b/%b/%h want=0/00/%h", err, err_code, obs, V_IDLE);
      end
   endtask

   task automatic test_stall_trap();
      logic [16:0] ev [8];
      logic        rv [8];
      ev = '{V_IDLE, V_FETCH_NOACK, V_FETCH_NOACK, V_FETCH_NOACK, V_FETCH_NOACK,
             V_FETCH_NOACK, V_TRAP, V_TRAP};
      rv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      op = 6'b000000; func = 6'b100000;
      for (int i = 0; i < 8; i++) begin
         tick(rv[i], 1'b0, 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL stall_cyc%0d got=%h want=%h", i, obs, ev[i]);
         end
      end
      checks++;
      if (err !== 1'b1 || err_code !== 2'b10) begin
         errors++; $display("FAIL stall_err got=%b/%b want=1/10", err, err_code);
      end
      $display("fetch never acked: err=%b err_code=%b", err, err_code);
      apply_reset();
   endtask

   initial begin
      reset_n     = 1'b0;
      run         = 1'b0;
      zero        = 1'b0;
      op          = 6'd0;
      func        = 6'd0;
      mif.mem_ack = 1'b0;

      V_IDLE        = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
      V_TRAP        = V_IDLE;
      V_FETCH_ACK   = exp_vec(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 1);
      V_FETCH_NOACK = exp_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 1);
      V_DECODE      = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1);
      V_EXEC_ADD    = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 1);
      V_EXEC_SUB    = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b110, 1);
      V_EXEC_I      = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 1);
      V_MEMADR      = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 1);
      V_ALUWB_R     = exp_vec(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 1);
      V_ALUWB_I     = exp_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1);
      V_MEMRD       = exp_vec(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1);
      V_MEMWR       = exp_vec(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1);
      V_MEMWB       = exp_vec(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1);
      V_BRANCH_T    = exp_vec(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1);
      V_BRANCH_N    = exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1);
      V_JUMP        = exp_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 1);

      test_reset();
      test_add();
      test_lw_wait();
      test_beq();
      test_back_to_back();
      test_sw_wait();
      test_run_drop();
      test_stall_ack5();
      test_reset_mid_memwr();
      test_illegal();
      test_stall_trap();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
